// File: rtl/tdc_result_averager.sv
// tdc_result_averager: averages 2^AVG_LOG2 measurement windows and offers the
// result through a single-entry valid/ready slot with sticky overrun.
// Optional macro TDC_AVG_MINMAX_EN adds per-group result_min/result_max.
module tdc_result_averager #(
    parameter int unsigned COUNTER_BITS = 8,
    parameter int unsigned AVG_LOG2     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    running,
    input  logic [COUNTER_BITS-1:0] count_in,
    input  logic                    result_ready,
    input  logic                    clr_ovr,
    output logic                    result_valid,
    output logic [COUNTER_BITS-1:0] result_data,
    output logic                    overrun,
    output logic [AVG_LOG2:0]       win_cnt
`ifdef TDC_AVG_MINMAX_EN
    ,
    output logic [COUNTER_BITS-1:0] result_min,
    output logic [COUNTER_BITS-1:0] result_max
`endif
);

    localparam int unsigned       ACC_W    = COUNTER_BITS + AVG_LOG2;
    localparam logic [AVG_LOG2:0] LAST_WIN = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

    typedef enum logic {
        EMPTY,
        FULL
    } slot_state_t;

    slot_state_t             state;
    slot_state_t             state_next;
    logic                    running_d;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        sum;
    logic [COUNTER_BITS-1:0] avg;
    logic                    eow;
    logic                    offer;
    logic                    load;
    logic                    drop;

    // End-of-window detection and group arithmetic
    always_comb begin
        eow   = running_d & ~running;
        offer = eow & (win_cnt == LAST_WIN);
        sum   = acc + ACC_W'(count_in);
        avg   = COUNTER_BITS'(sum >> AVG_LOG2);
    end

    // Window accumulation; never stalled by the output slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running_d <= 1'b0;
            acc       <= '0;
            win_cnt   <= '0;
        end else begin
            running_d <= running;
            if (eow) begin
                if (offer) begin
                    acc     <= '0;
                    win_cnt <= '0;
                end else begin
                    acc     <= sum;
                    win_cnt <= win_cnt + (AVG_LOG2 + 1)'(1);
                end
            end
        end
    end

    // Output slot state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_next;
    end

    // Output slot next-state logic
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (offer) state_next = FULL;
            FULL:  if (result_ready && !offer) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // Output slot decodes: a new average is loaded unless the slot is held
    always_comb begin
        result_valid = (state == FULL);
        load         = offer & ((state == EMPTY) | result_ready);
        drop         = offer & (state == FULL) & ~result_ready;
    end

    // Result register, only written when the slot accepts a new average
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       result_data <= '0;
        else if (load) result_data <= avg;
    end

    // Sticky overrun; a drop on the same edge overrides the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          overrun <= 1'b0;
        else if (drop)    overrun <= 1'b1;
        else if (clr_ovr) overrun <= 1'b0;
    end

`ifdef TDC_AVG_MINMAX_EN
    logic [COUNTER_BITS-1:0] grp_min;
    logic [COUNTER_BITS-1:0] grp_max;
    logic [COUNTER_BITS-1:0] new_min;
    logic [COUNTER_BITS-1:0] new_max;

    // Tracker values including the current window; first window seeds both
    always_comb begin
        if (win_cnt == '0) begin
            new_min = count_in;
            new_max = count_in;
        end else begin
            new_min = (count_in < grp_min) ? count_in : grp_min;
            new_max = (count_in > grp_max) ? count_in : grp_max;
        end
    end

    // Per-group trackers and their result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grp_min    <= '0;
            grp_max    <= '0;
            result_min <= '0;
            result_max <= '0;
        end else begin
            if (eow) begin
                grp_min <= new_min;
                grp_max <= new_max;
            end
            if (load) begin
                result_min <= new_min;
                result_max <= new_max;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tdc_result_averager.sv
// Testbench for tdc_result_averager: vector table, directed corner sequences,
// an AVG_LOG2=0 instance, and randomized traffic against a queue-based model.
module tb_tdc_result_averager;

    localparam int CB    = 8;
    localparam int L     = 2;
    localparam int GROUP = 1 << L;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          running;
    logic [CB-1:0] count_in;
    logic          result_ready;
    logic          clr_ovr;
    logic          result_valid;
    logic [CB-1:0] result_data;
    logic          overrun;
    logic [L:0]    win_cnt;

    logic          running0;
    logic [CB-1:0] count0;
    logic          valid0;
    logic [CB-1:0] data0;
    logic          ovr0;
    logic [0:0]    wc0;

`ifdef TDC_AVG_MINMAX_EN
    logic [CB-1:0] result_min;
    logic [CB-1:0] result_max;
    logic [CB-1:0] min0;
    logic [CB-1:0] max0;
`endif

    tdc_result_averager #(.COUNTER_BITS(CB), .AVG_LOG2(L)) u_dut (
        .clk(clk), .rst(rst), .running(running), .count_in(count_in),
        .result_ready(result_ready), .clr_ovr(clr_ovr),
        .result_valid(result_valid), .result_data(result_data),
        .overrun(overrun), .win_cnt(win_cnt)
`ifdef TDC_AVG_MINMAX_EN
        , .result_min(result_min), .result_max(result_max)
`endif
    );

    tdc_result_averager #(.COUNTER_BITS(CB), .AVG_LOG2(0)) u_dut0 (
        .clk(clk), .rst(rst), .running(running0), .count_in(count0),
        .result_ready(1'b1), .clr_ovr(1'b0),
        .result_valid(valid0), .result_data(data0),
        .overrun(ovr0), .win_cnt(wc0)
`ifdef TDC_AVG_MINMAX_EN
        , .result_min(min0), .result_max(max0)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: windows collected in a queue, slot as valid/data flags
    bit m_prev;
    int m_q[$];
    bit m_valid;
    int m_data;
    bit m_ovr;
    int m_min;
    int m_max;

    task automatic model_reset();
        m_prev = 0; m_q.delete(); m_valid = 0; m_data = 0; m_ovr = 0; m_min = 0; m_max = 0;
    endtask

    task automatic model_edge();
        int s, mn, mx, a;
        bit off, drop;
        off = 0; drop = 0; s = 0; mn = 0; mx = 0; a = 0;
        if (m_prev && !running) begin
            m_q.push_back(int'(count_in));
            if (m_q.size() == GROUP) begin
                mn = 1 << CB; mx = -1;
                foreach (m_q[i]) begin
                    s += m_q[i];
                    if (m_q[i] < mn) mn = m_q[i];
                    if (m_q[i] > mx) mx = m_q[i];
                end
                a = s / GROUP;
                off = 1;
                m_q.delete();
            end
        end
        m_prev = running;
        if (off) begin
            if (!m_valid || result_ready) begin
                m_valid = 1; m_data = a; m_min = mn; m_max = mx;
            end else drop = 1;
        end else if (result_ready) m_valid = 0;
        if (drop) m_ovr = 1;
        else if (clr_ovr) m_ovr = 0;
    endtask

    task automatic tick();
        model_edge();
        @(negedge clk);
    endtask

    task automatic win(input int v);
        running = 1; count_in = CB'(v);
        tick();
        running = 0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1; running = 0; count_in = '0; result_ready = 0; clr_ovr = 0; running0 = 0;
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    typedef struct {
        int c0, c1, c2, c3;
        int exp_data, exp_min, exp_max;
    } vec_t;

    vec_t vecs[7];
    int   seen;
    bit   nr;

    initial begin
        vecs[0] = '{10, 20, 30, 41, 25, 10, 41};
        vecs[1] = '{255, 255, 255, 255, 255, 255, 255};
        vecs[2] = '{0, 0, 0, 0, 0, 0, 0};
        vecs[3] = '{1, 1, 1, 0, 0, 0, 1};
        vecs[4] = '{3, 3, 3, 3, 3, 3, 3};
        vecs[5] = '{5, 200, 7, 9, 55, 5, 200};
        vecs[6] = '{254, 255, 255, 255, 254, 254, 255};

        rst = 1; running = 0; count_in = '0; result_ready = 0; clr_ovr = 0;
        running0 = 0; count0 = '0;
        repeat (2) @(negedge clk);
        rst = 0;
        model_reset();
        check("reset_valid", 32'(result_valid), 0);
        check("reset_data", 32'(result_data), 0);
        check("reset_ovr", 32'(overrun), 0);
        check("reset_wincnt", 32'(win_cnt), 0);

        // Table: four windows each, consumer always ready
        result_ready = 1;
        for (int i = 0; i < 7; i++) begin
            win(vecs[i].c0); win(vecs[i].c1); win(vecs[i].c2); win(vecs[i].c3);
            check($sformatf("tbl%0d_valid", i), 32'(result_valid), 1);
            check($sformatf("tbl%0d_data", i), 32'(result_data), 32'(vecs[i].exp_data));
            check($sformatf("tbl%0d_ovr", i), 32'(overrun), 0);
            check($sformatf("tbl%0d_wincnt", i), 32'(win_cnt), 0);
`ifdef TDC_AVG_MINMAX_EN
            check($sformatf("tbl%0d_min", i), 32'(result_min), 32'(vecs[i].exp_min));
            check($sformatf("tbl%0d_max", i), 32'(result_max), 32'(vecs[i].exp_max));
`endif
            tick();
            check($sformatf("tbl%0d_pulse", i), 32'(result_valid), 0);
        end

        // running held high or rising must not count as a window
        win(77);
        running = 1;
        for (int i = 0; i < 20; i++) begin
            count_in = CB'(i * 13);
            tick();
        end
        check("hold_high_wincnt", 32'(win_cnt), 1);
        check("hold_high_valid", 32'(result_valid), 0);
        running = 0;
        tick();
        check("hold_release_wincnt", 32'(win_cnt), 2);

        // Held result, second group dropped, then drain and clear
        do_reset();
        win(10); win(20); win(30); win(41);
        check("ovr_first_valid", 32'(result_valid), 1);
        check("ovr_first_data", 32'(result_data), 25);
        repeat (GROUP) win(100);
        check("ovr_held_data", 32'(result_data), 25);
        check("ovr_flag", 32'(overrun), 1);
        check("ovr_held_valid", 32'(result_valid), 1);
        result_ready = 1; tick(); result_ready = 0;
        check("ovr_drain_valid", 32'(result_valid), 0);
        check("ovr_sticky", 32'(overrun), 1);
        clr_ovr = 1; tick(); clr_ovr = 0;
        check("ovr_cleared", 32'(overrun), 0);

        // Ready on the exact completing edge transfers the old value
        win(10); win(20); win(30); win(41);
        check("simul_pre_data", 32'(result_data), 25);
        win(100); win(100); win(100);
        running = 1; count_in = 8'd100; tick();
        running = 0; result_ready = 1; tick(); result_ready = 0;
        check("simul_valid", 32'(result_valid), 1);
        check("simul_data", 32'(result_data), 100);
        check("simul_ovr", 32'(overrun), 0);

        // Drop and clear on the same edge: the drop wins
        win(8); win(8); win(8);
        running = 1; count_in = 8'd8; tick();
        running = 0; clr_ovr = 1; tick(); clr_ovr = 0;
        check("clrdrop_ovr", 32'(overrun), 1);
        check("clrdrop_data", 32'(result_data), 100);
        clr_ovr = 1; tick(); clr_ovr = 0;
        check("clr_after_drop", 32'(overrun), 0);

        // Reset in the middle of a group discards it
        do_reset();
        result_ready = 1;
        win(50); win(50);
        check("mid_wincnt", 32'(win_cnt), 2);
        rst = 1;
        #1;
        check("mid_reset_wincnt", 32'(win_cnt), 0);
        @(negedge clk);
        rst = 0;
        model_reset();
        result_ready = 1;
        repeat (GROUP) win(8);
        check("post_reset_valid", 32'(result_valid), 1);
        check("post_reset_data", 32'(result_data), 8);

        // AVG_LOG2=0 instance: pass-through per window
        running0 = 1; count0 = 8'd200; tick();
        running0 = 0; tick();
        check("pass_valid", 32'(valid0), 1);
        check("pass_data", 32'(data0), 200);
        running0 = 1;
        seen = 0;
        for (int i = 0; i < 1000; i++) begin
            count0 = CB'(i);
            tick();
            if (valid0) seen++;
        end
        check("pass_hold_high", 32'(seen), 0);
        running0 = 0;

        // Randomized traffic compared every cycle against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            nr = ($urandom_range(0, 2) == 0) ? ~running : running;
            if (nr) count_in = CB'($urandom_range(0, 255));
            running      = nr;
            result_ready = ($urandom_range(0, 3) == 0);
            clr_ovr      = ($urandom_range(0, 15) == 0);
            tick();
            check("rnd_valid", 32'(result_valid), 32'(m_valid));
            check("rnd_data", 32'(result_data), 32'(m_data));
            check("rnd_ovr", 32'(overrun), 32'(m_ovr));
            check("rnd_wincnt", 32'(win_cnt), 32'(m_q.size()));
`ifdef TDC_AVG_MINMAX_EN
            check("rnd_min", 32'(result_min), 32'(m_min));
            check("rnd_max", 32'(result_max), 32'(m_max));
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
